// File: rtl/z_run_monitor_if.sv
// Bus between the upstream sequence detector and the run monitor: detector
// inputs plus the registered statistics the monitor reports back.
interface z_run_monitor_if #(
  parameter int COUNT_W = 8,
  parameter int RUN_W   = 4
);
  logic               clear;
  logic               z;
  logic [4:0]         state;
  logic [COUNT_W-1:0] event_count;
  logic               event_pulse;
  logic [RUN_W-1:0]   run_len;
  logic [RUN_W-1:0]   max_run;
  logic               onehot_err;

  modport master (
    output clear, z, state,
    input  event_count, event_pulse, run_len, max_run, onehot_err
  );

  modport slave (
    input  clear, z, state,
    output event_count, event_pulse, run_len, max_run, onehot_err
  );
endinterface

// File: rtl/z_run_monitor.sv
// Statistics on the z output of an upstream one-hot FSM: rising-edge count and
// pulse, current and longest high run, and a sticky one-hot violation flag.
module z_run_monitor #(
  parameter int COUNT_W = 8,
  parameter int RUN_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  z_run_monitor_if.slave   mon
);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [RUN_W-1:0]   RUN_MAX   = '1;

  logic               z_prev_reg;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               pulse_reg, pulse_next;
  logic [RUN_W-1:0]   run_reg, run_next;
  logic [RUN_W-1:0]   max_reg, max_next;
  logic               err_reg, err_next;
  logic               rise;
  logic               state_bad;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign state_bad = (mon.state == 5'd0) || ((mon.state & (mon.state - 5'd1)) != 5'd0);
  assign rise      = mon.z & ~z_prev_reg;

  always_comb begin
    count_next = count_reg;
    pulse_next = 1'b0;
    run_next   = '0;
    max_next   = max_reg;
    err_next   = err_reg | state_bad;

    if (mon.clear) begin
      count_next = '0;
      max_next   = '0;
      err_next   = state_bad;
    end else begin
      pulse_next = rise;
      if (rise && (count_reg != COUNT_MAX)) begin
        count_next = count_reg + 1'b1;
      end
      if (mon.z) begin
        run_next = (run_reg == RUN_MAX) ? run_reg : run_reg + 1'b1;
      end
      // Compare against the value being loaded so max_run tracks run_len on the same edge.
      if (run_next > max_reg) begin
        max_next = run_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_prev_reg <= 1'b0;
      count_reg  <= '0;
      pulse_reg  <= 1'b0;
      run_reg    <= '0;
      max_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      z_prev_reg <= mon.z;
      count_reg  <= count_next;
      pulse_reg  <= pulse_next;
      run_reg    <= run_next;
      max_reg    <= max_next;
      err_reg    <= err_next;
    end
  end

  assign mon.event_count = count_reg;
  assign mon.event_pulse = pulse_reg;
  assign mon.run_len     = run_reg;
  assign mon.max_run     = max_reg;
  assign mon.onehot_err  = err_reg;
endmodule

// File: tb/tb_z_run_monitor.sv
// Directed and randomized bench for z_run_monitor; the reference model keeps the
// history of z samples since the last reset/clear and derives statistics from it.
module tb_z_run_monitor;
  localparam int CW = 8;
  localparam int RW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int RMAX = (1 << RW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  z_run_monitor_if #(.COUNT_W(CW), .RUN_W(RW)) bus ();

  z_run_monitor #(.COUNT_W(CW), .RUN_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Element 0 is the baseline (previous-z value); later elements are z per edge.
  bit seq[$];
  bit m_err;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
  endtask

  function automatic logic [4:0] oh(input int idx);
    return 5'd1 << idx;
  endfunction

  task automatic step(input bit r, input bit c, input bit zz, input logic [4:0] st);
    int rises, cur, best, n;
    bit e_pulse;
    reset     = r;
    bus.clear = c;
    bus.z     = zz;
    bus.state = st;
    @(posedge clk);
    if (r) begin
      seq.delete(); seq.push_back(1'b0); m_err = 1'b0;
    end else if (c) begin
      seq.delete(); seq.push_back(zz); m_err = ($countones(st) != 1);
    end else begin
      seq.push_back(zz);
      if ($countones(st) != 1) m_err = 1'b1;
    end
    rises = 0; cur = 0; best = 0;
    n = seq.size();
    for (int i = 1; i < n; i++) begin
      if (seq[i]) begin
        cur++;
        if (!seq[i-1]) rises++;
      end else begin
        cur = 0;
      end
      if (cur > best) best = cur;
    end
    e_pulse = (n >= 2) && seq[n-1] && !seq[n-2];
    #1;
    $display("t=%0t rst=%0b clr=%0b z=%0b st=%05b -> cnt=%0d pls=%0b run=%0d max=%0d err=%0b",
             $time, r, c, zz, st, bus.event_count, bus.event_pulse, bus.run_len,
             bus.max_run, bus.onehot_err);
    chk("event_count", int'(bus.event_count), (rises > CMAX) ? CMAX : rises);
    chk("event_pulse", int'(bus.event_pulse), int'(e_pulse));
    chk("run_len",     int'(bus.run_len),     (cur > RMAX) ? RMAX : cur);
    chk("max_run",     int'(bus.max_run),     (best > RMAX) ? RMAX : best);
    chk("onehot_err",  int'(bus.onehot_err),  int'(m_err));
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 1'b0, oh(0));
  endtask

  initial begin
    reset = 1'b1; bus.clear = 1'b0; bus.z = 1'b0; bus.state = oh(0);
    do_reset(3);

    // Basic run 0,1,1,1,0
    step(0, 0, 0, oh(0)); step(0, 0, 1, oh(1)); step(0, 0, 1, oh(2));
    step(0, 0, 1, oh(3)); step(0, 0, 0, oh(4));
    chk("basic_max_run", int'(bus.max_run), 3);
    chk("basic_count",   int'(bus.event_count), 1);

    // Event count saturation
    do_reset(2);
    for (int i = 0; i < 300; i++) step(0, 0, i[0], oh(i % 5));
    for (int i = 0; i < 400; i++) step(0, 0, ~i[0], oh(i % 5));
    chk("count_saturated", int'(bus.event_count), 255);

    // Run length saturation
    do_reset(2);
    for (int i = 0; i < 20; i++) step(0, 0, 1, oh(1));
    chk("run_saturated", int'(bus.run_len), 15);
    step(0, 0, 0, oh(1));
    chk("max_holds", int'(bus.max_run), 15);

    // Sticky one-hot error, clear interaction
    do_reset(2);
    step(0, 0, 0, 5'b00110);
    for (int i = 0; i < 3; i++) step(0, 0, 0, oh(i));
    chk("err_sticky", int'(bus.onehot_err), 1);
    step(0, 1, 0, oh(2));
    chk("err_cleared", int'(bus.onehot_err), 0);
    step(0, 1, 0, 5'b00000);
    chk("err_set_beats_clear", int'(bus.onehot_err), 1);
    step(0, 0, 0, oh(0));

    // Clear mid-run with z held high
    do_reset(2);
    for (int i = 0; i < 5; i++) step(0, 0, 1, oh(0));
    step(0, 1, 1, oh(0));
    for (int i = 0; i < 6; i++) step(0, 0, 1, oh(0));
    chk("post_clear_count", int'(bus.event_count), 0);
    chk("post_clear_run", int'(bus.run_len), 6);

    // Reset mid-run, released with z high
    do_reset(2);
    for (int i = 0; i < 5; i++) step(0, 0, 1, oh(3));
    step(1, 0, 1, oh(3)); step(1, 0, 1, oh(3));
    step(0, 0, 1, oh(3));
    chk("post_reset_pulse", int'(bus.event_pulse), 1);
    chk("post_reset_max", int'(bus.max_run), 1);

    // Randomized traffic with sticky z to produce long runs
    begin
      bit zr = 1'b0;
      for (int i = 0; i < 900; i++) begin
        logic [4:0] st;
        bit rr, cc;
        if ($urandom_range(0, 3) == 0) zr = ~zr;
        st = ($urandom_range(0, 15) == 0) ? 5'($urandom) : oh($urandom_range(0, 4));
        rr = ($urandom_range(0, 99) == 0);
        cc = ($urandom_range(0, 29) == 0);
        step(rr, cc, zr, st);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
